// File: rtl/count_seq_checker_if.sv
// Bus bundle for count_seq_checker: sampled code stream in, lock/error status out.
interface count_seq_checker_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned ERR_W = 8
);
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] in_code;
  logic             locked;
  logic             err;
  logic             illegal;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] exp_code;

  modport master (
    output clear, in_valid, in_code,
    input  locked, err, illegal, err_count, exp_code
  );

  modport slave (
    input  clear, in_valid, in_code,
    output locked, err, illegal, err_count, exp_code
  );
endinterface

// File: rtl/count_seq_checker.sv
// Monitors a modulo-MOD counter stream, locks after LOCK_CNT good steps, flags errors.
// Optional macro COUNT_SEQ_GRAY_DECODE_EN: treat in_code as Gray and decode before checking.
module count_seq_checker #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MOD      = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  count_seq_checker_if.slave  bus
);

  localparam int unsigned RUN_W = 4;
  localparam int unsigned CW    = WIDTH + 1;
  localparam logic [WIDTH:0]   MOD_C     = CW'(MOD);
  localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_CNT - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               have_ref_q, have_ref_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               illegal_q, illegal_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [WIDTH-1:0]   exp_code_q, exp_code_d;

  logic [WIDTH-1:0]   code_c;
  logic               legal_c;
  logic               match_c;
  logic               lock_hit_c;

  // Successor computed one bit wider so MOD = 2^WIDTH cannot overflow.
  function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] nx;
    nx = {1'b0, x} + CW'(1);
    return (nx == MOD_C) ? '0 : WIDTH'(nx);
  endfunction

`ifdef COUNT_SEQ_GRAY_DECODE_EN
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign code_c = gray2bin(bus.in_code);
`else
  assign code_c = bus.in_code;
`endif

  assign legal_c    = ({1'b0, code_c} < MOD_C);
  assign match_c    = (code_c == exp_code_q);
  assign lock_hit_c = have_ref_q && match_c && (run_q == LOCK_LAST);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      have_ref_q  <= 1'b0;
      run_q       <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      illegal_q   <= 1'b0;
      err_count_q <= '0;
      exp_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      have_ref_q  <= have_ref_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      illegal_q   <= illegal_d;
      err_count_q <= err_count_d;
      exp_code_q  <= exp_code_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = HUNT;
    end else if (bus.in_valid) begin
      case (state_q)
        HUNT:    if (legal_c && lock_hit_c) state_d = LOCKED;
        LOCKED:  if (!legal_c || !match_c)  state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    have_ref_d  = have_ref_q;
    run_d       = run_q;
    exp_code_d  = exp_code_q;
    err_count_d = err_count_q;
    err_d       = 1'b0;
    illegal_d   = 1'b0;
    locked_d    = (state_d == LOCKED);

    if (bus.clear) begin
      have_ref_d  = 1'b0;
      run_d       = '0;
      err_count_d = '0;
      exp_code_d  = '0;
    end else if (bus.in_valid) begin
      if (!legal_c) begin
        // Illegal code drops the reference but leaves exp_code alone.
        illegal_d  = 1'b1;
        have_ref_d = 1'b0;
        run_d      = '0;
        err_d      = (state_q == LOCKED);
      end else if (state_q == LOCKED) begin
        exp_code_d = succ(code_c);
        if (!match_c) begin
          err_d      = 1'b1;
          have_ref_d = 1'b1;
          run_d      = '0;
        end
      end else begin
        exp_code_d = succ(code_c);
        have_ref_d = 1'b1;
        if (have_ref_q && match_c) begin
          run_d = run_q + RUN_W'(1);
        end else begin
          run_d = '0;
        end
      end

      if (err_d && (err_count_q != '1)) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.illegal   = illegal_q;
  assign bus.err_count = err_count_q;
  assign bus.exp_code  = exp_code_q;

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receive-side monitor for the team's counter and sequence-generator blocks.
- Samples a WIDTH-bit code stream and checks that each valid sample is the modulo-MOD successor of the previous one.
- After LOCK_CNT consecutive correct steps it declares lock. While locked it flags sequence errors and illegal codes, and keeps a saturating error count.

Parameters:
- WIDTH, 3, code width in bits.
- MOD, 8, counter modulus; legal codes are 0..MOD-1; range 2..2^WIDTH.
- LOCK_CNT, 4, consecutive correct successors needed for lock; range 1..15.
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear: err_count=0, return to HUNT.
- in_valid  input  1  in_code is sampled this cycle.
- in_code  input  WIDTH  observed counter code.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse on a mismatch while LOCKED.
- illegal  output  1  one-cycle pulse when a sampled code is >= MOD.
- err_count  output  ERR_W  saturating count of err pulses.
- exp_code  output  WIDTH  next expected code.

Behaviour:
- All outputs are registered and update on the clk edge that samples in_valid=1.
- Reset (reset=0), applied immediately: state HUNT, have_ref=0, run=0, locked=0, err=0, illegal=0, err_count=0, exp_code=0.
- succ(x): x+1, or 0 when x=MOD-1. Computed at WIDTH+1 bits internally, so there is no width overflow.
- in_valid=0: no state change; err=0 and illegal=0.
- clear=1 has priority over in_valid. Result: HUNT, have_ref=0, run=0, err_count=0, exp_code=0, pulses 0.
- HUNT, have_ref=0, legal code c:
  - exp_code=succ(c), have_ref=1, run=0.
- HUNT, have_ref=1, c==exp_code:
  - exp_code=succ(c), run=run+1.
  - If run+1==LOCK_CNT: go to LOCKED, locked=1 from the next cycle.
- HUNT, have_ref=1, c!=exp_code (legal):
  - Re-seed: exp_code=succ(c), run=0.
  - No err pulse; err fires only in LOCKED.
- LOCKED, c==exp_code: exp_code=succ(c).
- LOCKED, c!=exp_code:
  - err=1 for one cycle; err_count increments, saturating at 2^ERR_W-1.
  - Go to HUNT, locked=0.
  - If c is legal: have_ref=1, exp_code=succ(c), run=0.
- Illegal code c>=MOD, in any state:
  - illegal=1 for one cycle; have_ref=0, run=0, exp_code unchanged.
  - In LOCKED it also counts as a mismatch: err=1, err_count increments, go to HUNT.
- LOCK_CNT=1: one correct successor after the seed gives lock.
- Wrap: MOD-1 followed by 0 is correct and is never an error.

Optional Feature:
- Macro: COUNT_SEQ_GRAY_DECODE_EN.
- Defined: in_code is Gray-coded. It is converted to binary combinationally (b[MSB]=g[MSB], b[i]=b[i+1]^g[i]) before every check. The illegal check applies to the decoded value. exp_code stays binary.
- Undefined: in_code is used as plain binary; no decode logic is present.

Test Plan:
- Lock, WIDTH=3 MOD=8 LOCK_CNT=4: reset, then valid codes 0,1,2,3,4 on consecutive cycles -> locked=1 the cycle after 4 is sampled, exp_code=5, err=0 throughout.
- Skip while locked: from lock, feed 5,7 -> err=1 for exactly one cycle after 7, err_count=1, locked=0, exp_code=0. Then feed 0,1,2,3 -> relock.
- Modulus wrap, MOD=6: feed 2,3,4,5,0,1 -> locked, no err. Then feed 6 -> illegal=1 and err=1, err_count=1, locked=0.
- Saturation, ERR_W=2: five lock/mismatch cycles -> err_count sticks at 3. Assert clear with in_valid=1 -> err_count=0, locked=0, exp_code=0.
- Async reset mid-stream: pull reset low between clock edges while locked -> locked, err_count and exp_code go to 0 without waiting for a clock edge. No lock until 0..4 is re-fed after release.
- Gray, macro defined: feed 000,001,011,010,110 -> locked=1, exp_code=5. Macro undefined, same stream -> never locks.
